// File: rtl/serial_add_pkg.sv
// Shared encodings for the bit-serial adder/subtractor controller.
package serial_add_pkg;

    // Controller state encodings
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Operation select encodings
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        StIdle = IDLE,
        StRun  = RUN,
        StDone = DONE
    } state_e;

endpackage

// File: rtl/fa.sv
// One-bit full-adder cell; the whole datapath of the serial adder.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic su,
    output logic carry
);

    // Sum and carry-out of a single bit position
    always_comb begin
        su    = a ^ b ^ cin;
        carry = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder evaluation per RUN cycle,
// result shifted in LSB-first, done pulsed for one cycle after WIDTH steps.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    import serial_add_pkg::*;

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CNT_W-1:0] r_cnt;

    logic             w_su;
    logic             w_carry;

    fa u_fa (
        .a     (r_a[0]),
        .b     (r_b[0]),
        .cin   (r_carry),
        .su    (w_su),
        .carry (w_carry)
    );

    // Controller FSM plus operand/result shift registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_a     <= a;
                        // Subtraction is a + ~b + 1
                        r_b     <= (op == OP_SUB) ? ~b : b;
                        r_carry <= (op == OP_ADD) ? cin : 1'b1;
                        r_cnt   <= '0;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    r_sum   <= {w_su, r_sum[WIDTH-1:1]};
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_carry;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_cout  <= w_carry;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Status outputs are straight decodes of the state register
    always_comb begin
        busy = (r_state != StIdle);
        done = (r_state == StDone);
        sum  = r_sum;
        cout = r_cout;
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: 8-bit vector table, multi-cycle
// corner sequences, and an exhaustive sweep on a 2-bit instance.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, op8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start2, op2, cin2;
    logic [1:0] a2, b2;
    logic       busy2, done2, cout2;
    logic [1:0] sum2;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .op    (op8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_add_ctrl #(.WIDTH(2)) u_dut2 (
        .clk   (clk),
        .rst   (rst),
        .start (start2),
        .op    (op2),
        .a     (a2),
        .b     (b2),
        .cin   (cin2),
        .busy  (busy2),
        .done  (done2),
        .sum   (sum2),
        .cout  (cout2)
    );

    typedef struct {
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    typedef struct {
        logic [7:0] s;
        logic       c;
    } exp_t;

    vec_t vecs[10];
    exp_t sb8[$];
    exp_t sb2[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // One 8-bit operation; inject >= 0 pulses a competing start in that RUN cycle
    task automatic run8(input logic op, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [7:0] es, input logic ec,
                        input int inject);
        exp_t e;
        int   cyc;
        int   busy_cnt;
        int   extra_done;
        @(negedge clk);
        op8 = op; a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
        e.s = es; e.c = ec;
        sb8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        // Operand changes after acceptance must not matter
        a8 = 8'($urandom); b8 = 8'($urandom); op8 = 1'($urandom); cin8 = 1'($urandom);
        cyc = 0;
        busy_cnt = 0;
        while (!done8 && cyc < 40) begin
            if (busy8) busy_cnt++;
            if (cyc == inject) begin
                start8 = 1'b1; a8 = ~a; b8 = ~b; op8 = ~op; cin8 = ~cin;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start8 = 1'b0;
        if (!done8) begin
            check("done_timeout", 32'(done8), 32'd1);
            void'(sb8.pop_front());
            return;
        end
        e = sb8.pop_front();
        check("latency", 32'(cyc), 32'd8);
        check("busy_run_cycles", 32'(busy_cnt), 32'd8);
        check("busy_in_done", 32'(busy8), 32'd1);
        check("sum", 32'(sum8), 32'(e.s));
        check("cout", 32'(cout8), 32'(e.c));
        @(negedge clk);
        check("done_single_pulse", 32'(done8), 32'd0);
        check("busy_after_done", 32'(busy8), 32'd0);
        check("sum_hold", 32'(sum8), 32'(e.s));
        if (inject >= 0) begin
            extra_done = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (done8) extra_done++;
            end
            check("ignored_start_no_done", 32'(extra_done), 32'd0);
        end
    endtask

    // One 2-bit operation checked against an arithmetic reference
    task automatic run2(input logic op, input logic [1:0] a, input logic [1:0] b,
                        input logic cin);
        exp_t       e;
        logic [2:0] ref_val;
        int         cyc;
        @(negedge clk);
        op2 = op; a2 = a; b2 = b; cin2 = cin; start2 = 1'b1;
        if (op) ref_val = {1'b0, a} + {1'b0, ~b} + 3'd1;
        else    ref_val = {1'b0, a} + {1'b0, b} + {2'b00, cin};
        e.s = {6'd0, ref_val[1:0]};
        e.c = ref_val[2];
        sb2.push_back(e);
        @(negedge clk);
        start2 = 1'b0;
        cyc = 0;
        while (!done2 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        e = sb2.pop_front();
        if (!done2) begin
            check("w2_done_timeout", 32'(done2), 32'd1);
            return;
        end
        check("w2_latency", 32'(cyc), 32'd2);
        check("w2_sum", 32'(sum2), 32'(e.s[1:0]));
        check("w2_cout", 32'(cout2), 32'(e.c));
    endtask

    initial begin
        exp_t e;
        int   cyc;
        int   first_done;
        int   n_done;
        int   extra_done;

        vecs[0] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{1'b0, 8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0};
        vecs[2] = '{1'b1, 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1};
        vecs[3] = '{1'b1, 8'h01, 8'h02, 1'b0, 8'hFF, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[5] = '{1'b0, 8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
        vecs[6] = '{1'b1, 8'h55, 8'h55, 1'b0, 8'h00, 1'b1};
        vecs[7] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[8] = '{1'b1, 8'h00, 8'hFF, 1'b1, 8'h01, 1'b0};
        vecs[9] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

        // Reset with start held high: nothing may be accepted
        rst = 1'b1;
        start8 = 1'b1; op8 = 1'b0; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
        start2 = 1'b0; op2 = 1'b0; a2 = 2'd0; b2 = 2'd0; cin2 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy8), 32'd0);
        check("reset_done", 32'(done8), 32'd0);
        check("reset_sum", 32'(sum8), 32'd0);
        check("reset_cout", 32'(cout8), 32'd0);
        rst = 1'b0;
        start8 = 1'b0;

        foreach (vecs[i]) begin
            run8(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin,
                 vecs[i].exp_sum, vecs[i].exp_cout, -1);
        end

        // Competing start in RUN cycle 3 is dropped
        run8(1'b0, 8'h21, 8'h43, 1'b0, 8'h64, 1'b0, 2);

        // Reset in RUN cycle 4 aborts the operation
        @(negedge clk);
        op8 = 1'b0; a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before_rst", 32'(busy8), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_sum", 32'(sum8), 32'd0);
        check("abort_cout", 32'(cout8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) extra_done++;
        end
        check("abort_no_done", 32'(extra_done), 32'd0);
        run8(1'b1, 8'hC8, 8'h37, 1'b0, 8'h91, 1'b1, -1);

        // Start held high: back-to-back results every WIDTH+2 cycles
        @(negedge clk);
        op8 = 1'b0; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        e.s = 8'h46; e.c = 1'b0;
        sb8.push_back(e);
        sb8.push_back(e);
        cyc = 0; n_done = 0; first_done = 0;
        while (n_done < 2 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done8) begin
                n_done++;
                e = sb8.pop_front();
                check("held_sum", 32'(sum8), 32'(e.s));
                check("held_cout", 32'(cout8), 32'(e.c));
                if (n_done == 1) first_done = cyc;
                else check("held_throughput", 32'(cyc - first_done), 32'd10);
            end
        end
        start8 = 1'b0;
        check("held_done_count", 32'(n_done), 32'd2);
        sb8.delete();

        // Exhaustive sweep of the 2-bit instance
        for (int o = 0; o < 2; o++)
            for (int x = 0; x < 4; x++)
                for (int y = 0; y < 4; y++)
                    for (int c = 0; c < 2; c++)
                        run2(1'(o), 2'(x), 2'(y), 1'(c));

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  1  0 = add, 1 = subtract (a - b).
REQ-006 a  input  WIDTH  operand A; captured on accepted start.
REQ-007 b  input  WIDTH  operand B; captured on accepted start.
REQ-008 cin  input  1  carry-in for add; ignored when op=1.
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 done  output  1  single-cycle pulse; result valid.
REQ-011 sum  output  WIDTH  result, LSB-first accumulated.
REQ-012 cout  output  1  final carry (op=1: 1 = no borrow).

Function
REQ-013 FSM states: IDLE, RUN, DONE; one 1-bit full-adder cell evaluated per RUN cycle.
REQ-014 IDLE -> RUN on edge where start=1; capture a, b (b inverted when op=1), carry register <= (op ? 1 : cin), bit counter <= 0.
REQ-015 IDLE with start=0: hold state; sum and cout keep last result.
REQ-016 RUN, each edge: adder bit = A_reg[0] ^ B_reg[0] ^ carry; shift adder bit into sum MSB, shift sum, A_reg and B_reg right one place; carry <= full-adder carry-out; counter += 1.
REQ-017 RUN -> DONE on the edge where counter = WIDTH-1 (i.e. after exactly WIDTH RUN edges); cout <= final carry on that edge.
REQ-018 DONE -> IDLE unconditionally on next edge; done=1 only while in DONE.
REQ-019 Latency: start accepted at edge k; done high in cycle following edge k+WIDTH; sum/cout valid from then until next accepted start.
REQ-020 start while busy=1 ignored, no queuing; start held high continuously re-accepted on edge after DONE (throughput one result per WIDTH+2 cycles).
REQ-021 Changes on a, b, op, cin after acceptance have no effect on the operation in progress.
REQ-022 Arithmetic modulo 2^WIDTH; overflow not flagged; cout is the only carry indication.
REQ-023 sum register modified only in RUN; partial values visible during RUN, meaningful only when done=1.

Reset
REQ-024 rst=1 at an edge forces IDLE, sum=0, cout=0, done=0, busy=0, carry=0, counter=0, regardless of state.
REQ-025 rst asserted mid-RUN aborts the operation; no done pulse issued for it.
REQ-026 start sampled while rst=1 is ignored; first acceptance possible on the first edge with rst=0.

Structure
REQ-027 Shared package serial_add_pkg holds state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and op encoding constants (OP_ADD=0, OP_SUB=1).
REQ-028 Exactly one sub-module: the existing 1-bit full-adder cell fa (ports a, b, cin, su, carry), instantiated once as the datapath.
REQ-029 Counter width $clog2(WIDTH); no other arithmetic operators in the controller.

Verification
REQ-030 WIDTH=8, op=0, a=0xFF, b=0x01, cin=0 -> done after 9 edges, sum=0x00, cout=1.
REQ-031 op=0, a=0x5A, b=0x3C, cin=1 -> sum=0x97, cout=0; busy high exactly 9 cycles (RUN x8 + DONE).
REQ-032 op=1, a=0x10, b=0x01, cin=1 -> sum=0x0F, cout=1; op=1, a=0x01, b=0x02 -> sum=0xFF, cout=0.
REQ-033 Pulse start again at RUN cycle 3 with different operands -> ignored; original result delivered, single done pulse.
REQ-034 Assert rst at RUN cycle 4 -> next cycle busy=0, sum=0x00, cout=0, no done; new start then completes correctly.
REQ-035 Exhaustive WIDTH=2, all a, b, cin, op combinations against a reference model -> every sum/cout matches.
